vga_timing_ctrl: RTL and testbench

// - Video timing controller that sequences the pixel-pattern generator and drives the HDMI/VGA encoder.
// - Runs H/V counters and issues pixel coordinates plus a request strobe one pipeline stage ahead.
// - Takes back 16-bit RGB565 data with fixed 1-cycle registered latency.
// - Emits aligned hsync/vsync/de/rgb, with clean start/stop at frame boundaries.

---
 rtl/vga_timing_pkg.sv | 45 ++++
 rtl/vga_timing_ctrl_counter.sv | 39 +++
 rtl/vga_timing_ctrl.sv | 140 ++++++++++++++
 tb/tb_vga_timing_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing sets, RGB565 colours and controller state encoding for the
// video timing controller.
package vga_timing_pkg;

    localparam int CNT_W         = 12;
    localparam int CNT_MAX_TOTAL = 4096;

    typedef struct packed {
        int h_sync;
        int h_back;
        int h_valid;
        int h_front;
        int v_sync;
        int v_back;
        int v_valid;
        int v_front;
    } timing_t;

    localparam timing_t TIMING_1080P60 = '{
        h_sync: 44, h_back: 148, h_valid: 1920, h_front: 88,
        v_sync: 5,  v_back: 36,  v_valid: 1080, v_front: 4
    };

    localparam timing_t TIMING_720P60 = '{
        h_sync: 40, h_back: 220, h_valid: 1280, h_front: 110,
        v_sync: 5,  v_back: 20,  v_valid: 720,  v_front: 5
    };

    localparam logic [15:0] RGB565_BLACK = 16'h0000;
    localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
    localparam logic [15:0] RGB565_RED   = 16'hF800;
    localparam logic [15:0] RGB565_GREEN = 16'h07E0;
    localparam logic [15:0] RGB565_BLUE  = 16'h001F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic logic in_window(input int cnt, input int lo, input int len);
        return (cnt >= lo) && (cnt < lo + len);
    endfunction

endpackage

// File: rtl/vga_timing_ctrl_counter.sv
// Horizontal/vertical position counter pair; flags the last pixel of a frame.
module vga_hv_counter
    import vga_timing_pkg::*;
#(
    parameter int H_TOTAL = 2200,
    parameter int V_TOTAL = 1125
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             run,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             frame_last
);

    localparam logic [CNT_W-1:0] H_MAX = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_MAX = CNT_W'(V_TOTAL - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (clear) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (run) begin
            if (h_cnt == H_MAX) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_MAX) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    assign frame_last = (h_cnt == H_MAX) && (v_cnt == V_MAX);

endmodule

// File: rtl/vga_timing_ctrl.sv
// Video timing controller: frame sequencing FSM, stage-0 pixel request decode
// and a two-stage pipeline aligning sync/de with the returned pixel data.
//
// state | meaning
// IDLE  | counters held at 0, no requests, pipeline drains to inactive levels
// RUN   | frames generated back to back while en_i is high
// DRAIN | en_i dropped; current frame finishes, then IDLE (or RUN if re-enabled)
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int H_SYNC   = TIMING_1080P60.h_sync,
    parameter int H_BACK   = TIMING_1080P60.h_back,
    parameter int H_VALID  = TIMING_1080P60.h_valid,
    parameter int H_FRONT  = TIMING_1080P60.h_front,
    parameter int V_SYNC   = TIMING_1080P60.v_sync,
    parameter int V_BACK   = TIMING_1080P60.v_back,
    parameter int V_VALID  = TIMING_1080P60.v_valid,
    parameter int V_FRONT  = TIMING_1080P60.v_front,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic             sys_clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic [15:0]      pix_data_i,
    output logic             pix_req_o,
    output logic [CNT_W-1:0] pix_x_o,
    output logic [CNT_W-1:0] pix_y_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             de_o,
    output logic [15:0]      rgb_o,
    output logic             frame_start_o,
    output logic             busy_o
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
    localparam int H_OFF   = H_SYNC + H_BACK;
    localparam int V_OFF   = V_SYNC + V_BACK;

    if (H_TOTAL > CNT_MAX_TOTAL || V_TOTAL > CNT_MAX_TOTAL) begin : g_size_check
        $error("vga_timing_ctrl: H_TOTAL/V_TOTAL exceed 12-bit counter range");
    end

    state_t           state;
    state_t           state_nxt;
    logic             running;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             frame_last;

    assign running = (state != ST_IDLE);

    vga_hv_counter #(
        .H_TOTAL(H_TOTAL),
        .V_TOTAL(V_TOTAL)
    ) u_hv_counter (
        .clk       (sys_clk_i),
        .rst_n     (rst_n_i),
        .clear     (~running),
        .run       (running),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .frame_last(frame_last)
    );

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Dropping enable on the very last pixel already completes the frame.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (en_i) state_nxt = ST_RUN;
            ST_RUN:   if (!en_i) state_nxt = frame_last ? ST_IDLE : ST_DRAIN;
            ST_DRAIN: begin
                if (en_i)            state_nxt = ST_RUN;
                else if (frame_last) state_nxt = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    logic h_act;
    logic v_act;
    logic hs_s0;
    logic vs_s0;
    logic fs_s0;

    assign h_act  = in_window(int'(h_cnt), H_OFF, H_VALID);
    assign v_act  = in_window(int'(v_cnt), V_OFF, V_VALID);
    assign hs_s0  = running & (h_cnt < CNT_W'(H_SYNC));
    assign vs_s0  = running & (v_cnt < CNT_W'(V_SYNC));
    assign fs_s0  = running & (h_cnt == '0) & (v_cnt == '0);

    assign pix_req_o = running & h_act & v_act;
    assign pix_x_o   = pix_req_o ? h_cnt - CNT_W'(H_OFF) : '0;
    assign pix_y_o   = pix_req_o ? v_cnt - CNT_W'(V_OFF) : '0;

    logic hs_s1;
    logic vs_s1;
    logic de_s1;
    logic fs_s1;

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hs_s1 <= 1'b0;
            vs_s1 <= 1'b0;
            de_s1 <= 1'b0;
            fs_s1 <= 1'b0;
        end else begin
            hs_s1 <= hs_s0;
            vs_s1 <= vs_s0;
            de_s1 <= pix_req_o;
            fs_s1 <= fs_s0;
        end
    end

    // Pixel data arrives during stage 1, so stage 2 lines it up with de.
    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hsync_o       <= ~SYNC_POL;
            vsync_o       <= ~SYNC_POL;
            de_o          <= 1'b0;
            rgb_o         <= '0;
            frame_start_o <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            hsync_o       <= hs_s1 ? SYNC_POL : ~SYNC_POL;
            vsync_o       <= vs_s1 ? SYNC_POL : ~SYNC_POL;
            de_o          <= de_s1;
            rgb_o         <= de_s1 ? pix_data_i : '0;
            frame_start_o <= fs_s1;
            busy_o        <= (state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Self-checking bench for vga_timing_ctrl on a tiny 14x7 raster: a
// position-based frame model predicts every output each cycle.
module tb_vga_timing_ctrl;

    localparam int HS = 2, HB = 2, HV = 8, HF = 2;
    localparam int VS = 1, VB = 1, VV = 4, VF = 1;
    localparam int HT = HS + HB + HV + HF;
    localparam int VT = VS + VB + VV + VF;
    localparam int FT = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] pix_data = 16'h0;
    logic        pix_req;
    logic [11:0] pix_x;
    logic [11:0] pix_y;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [15:0] rgb;
    logic        frame_start;
    logic        busy;

    always #5 clk = ~clk;

    vga_timing_ctrl #(
        .H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_FRONT(VF),
        .SYNC_POL(1'b1)
    ) dut (
        .sys_clk_i    (clk),
        .rst_n_i      (rst_n),
        .en_i         (en),
        .pix_data_i   (pix_data),
        .pix_req_o    (pix_req),
        .pix_x_o      (pix_x),
        .pix_y_o      (pix_y),
        .hsync_o      (hsync),
        .vsync_o      (vsync),
        .de_o         (de),
        .rgb_o        (rgb),
        .frame_start_o(frame_start),
        .busy_o       (busy)
    );

    typedef struct {
        bit req;
        bit hs;
        bit vs;
        bit de;
        bit fs;
        int x;
        int y;
    } dec_t;

    // Model: frame position 0..FT-1 while active, plus two cycles of history.
    int         m_pos;
    bit         m_act;
    dec_t       hist1;
    dec_t       hist2;
    logic [7:0] salt;
    int         n_checks = 0;
    int         n_err = 0;

    function automatic dec_t decode_pos(input bit act, input int pos);
        dec_t d;
        int   h;
        int   v;
        d = '{default: 0};
        if (act) begin
            h    = pos % HT;
            v    = pos / HT;
            d.hs = (h < HS);
            d.vs = (v < VS);
            d.fs = (pos == 0);
            d.de = (h >= HS + HB) && (h < HS + HB + HV) && (v >= VS + VB) && (v < VS + VB + VV);
            d.req = d.de;
            if (d.req) begin
                d.x = h - (HS + HB);
                d.y = v - (VS + VB);
            end
        end
        return d;
    endfunction

    task automatic model_reset();
        m_act = 1'b0;
        m_pos = 0;
        hist1 = '{default: 0};
        hist2 = '{default: 0};
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        dec_t        c;
        logic [15:0] exp_rgb;
        c = decode_pos(m_act, m_pos);
        exp_rgb = hist2.de ? {4'(hist2.y), 4'(hist2.x), salt} : 16'h0;
        chk("pix_req", 32'(pix_req), 32'(c.req));
        chk("pix_x", 32'(pix_x), 32'(c.x));
        chk("pix_y", 32'(pix_y), 32'(c.y));
        chk("hsync", 32'(hsync), 32'(hist2.hs));
        chk("vsync", 32'(vsync), 32'(hist2.vs));
        chk("de", 32'(de), 32'(hist2.de));
        chk("rgb", 32'(rgb), 32'(exp_rgb));
        chk("frame_start", 32'(frame_start), 32'(hist2.fs));
        chk("busy", 32'(busy), 32'(m_act));
    endtask

    // One clock: pattern generator registers {y,x,salt}, model advances, outputs checked.
    task automatic tick();
        logic [15:0] gen;
        dec_t        c;
        gen = pix_req ? {pix_y[3:0], pix_x[3:0], salt} : 16'($urandom);
        c = decode_pos(m_act, m_pos);
        if (!rst_n) begin
            model_reset();
        end else begin
            hist2 = hist1;
            hist1 = c;
            if (m_act) begin
                if (m_pos == FT - 1 && !en) begin
                    m_act = 1'b0;
                    m_pos = 0;
                end else begin
                    m_pos = (m_pos + 1) % FT;
                end
            end else if (en) begin
                m_act = 1'b1;
                m_pos = 0;
            end
        end
        @(posedge clk);
        #1;
        pix_data = gen;
        check_all();
    endtask

    initial begin
        int k;
        bit found;
        int nh, nv, nd, nf, last_fs;

        salt = 8'($urandom);
        model_reset();

        // Reset held with enable high: everything stays inactive.
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (4) tick();
        #4 rst_n = 1'b1;

        // Start-up latency: first request at v=2,h=4, then de two cycles later.
        k = -1;
        found = 1'b0;
        for (int i = 1; i <= 200 && !found; i++) begin
            tick();
            if (pix_req) begin
                found = 1'b1;
                k = i;
            end
        end
        chk("first_req_tick", 32'(k), 32'(HT * (VS + VB) + (HS + HB) + 1));
        k = -1;
        found = 1'b0;
        for (int i = 1; i <= 10 && !found; i++) begin
            tick();
            if (de) begin
                found = 1'b1;
                k = i;
            end
        end
        chk("de_lag", 32'(k), 32'd2);

        // Three free-running frames measured from a frame_start.
        for (int i = 0; i < 200 && !frame_start; i++) tick();
        chk("fs_seen", 32'(frame_start), 32'd1);
        nh = 0; nv = 0; nd = 0; nf = 0; last_fs = -1;
        for (int i = 0; i < 3 * FT; i++) begin
            nh += int'(hsync);
            nv += int'(vsync);
            nd += int'(de);
            if (frame_start) begin
                if (last_fs >= 0) chk("fs_spacing", 32'(i - last_fs), 32'(FT));
                last_fs = i;
                nf++;
            end
            tick();
        end
        chk("hsync_count", 32'(nh), 32'(3 * VT * HS));
        chk("vsync_count", 32'(nv), 32'(3 * VS * HT));
        chk("de_count", 32'(nd), 32'(3 * HV * VV));
        chk("fs_count", 32'(nf), 32'd3);

        // Disable at v=3,h=5: frame completes, busy falls right after the last pixel.
        for (int i = 0; i < 200 && !(m_act && m_pos == 3 * HT + 5); i++) tick();
        chk("drain_point_x", 32'(pix_x), 32'd1);
        chk("drain_point_y", 32'(pix_y), 32'd1);
        en = 1'b0;
        k = -1;
        found = 1'b0;
        for (int i = 1; i <= 200 && !found; i++) begin
            tick();
            if (!busy) begin
                found = 1'b1;
                k = i;
            end
        end
        chk("busy_fall_ticks", 32'(k), 32'(FT - (3 * HT + 5)));
        tick();
        tick();
        chk("idle_hsync", 32'(hsync), 32'd0);
        chk("idle_vsync", 32'(vsync), 32'd0);
        chk("idle_de", 32'(de), 32'd0);
        repeat (5) tick();

        // Re-enable, then a short enable drop inside the frame must not disturb cadence.
        en = 1'b1;
        for (int i = 0; i < 200 && !frame_start; i++) tick();
        chk("restart_fs", 32'(frame_start), 32'd1);
        k = -1;
        found = 1'b0;
        for (int i = 1; i <= 300 && !found; i++) begin
            if (i == 39) en = 1'b0;
            if (i == 49) en = 1'b1;
            tick();
            if (frame_start) begin
                found = 1'b1;
                k = i;
            end
        end
        chk("fs_spacing_redrive", 32'(k), 32'(FT));

        // Asynchronous reset between edges at v=3,h=6.
        for (int i = 0; i < 200 && !(m_act && m_pos == 3 * HT + 6); i++) tick();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("async_busy", 32'(busy), 32'd0);
        #1 rst_n = 1'b1;
        k = -1;
        found = 1'b0;
        for (int i = 1; i <= 20 && !found; i++) begin
            tick();
            if (frame_start) begin
                found = 1'b1;
                k = i;
            end
        end
        // One edge to leave IDLE, then two pipeline stages.
        chk("reset_restart_fs", 32'(k), 32'd3);

        // Random enable toggling against the model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 29) == 0) en = ~en;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
